// File: rtl/seg7_scan_counter.sv
// Hex up/down counter driven by two debounced buttons, with a multiplexed
// 7-segment display driver (one-hot digit select, shared segment lines).
module seg7_scan_counter #(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned TICK_DIV       = 8388608,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEB_CYCLES     = 500000,
    parameter bit          SATURATE       = 1'b0,
    parameter bit          BLANK_LZ       = 1'b0,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [1:0]            BTN,
    output logic [6:0]            SEG,
    output logic [DIGITS-1:0]     DIG,
    output logic [4*DIGITS-1:0]   VALUE,
    output logic                  WRAP
);

    localparam int unsigned VW = 4 * DIGITS;
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [6:0]        SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_POL = {DIGITS{DIG_ACTIVE_LOW}};

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b1111110;
            4'h1: hex7 = 7'b0110000;
            4'h2: hex7 = 7'b1101101;
            4'h3: hex7 = 7'b1111001;
            4'h4: hex7 = 7'b0110011;
            4'h5: hex7 = 7'b1011011;
            4'h6: hex7 = 7'b1011111;
            4'h7: hex7 = 7'b1110000;
            4'h8: hex7 = 7'b1111111;
            4'h9: hex7 = 7'b1111011;
            4'hA: hex7 = 7'b1110111;
            4'hB: hex7 = 7'b0011111;
            4'hC: hex7 = 7'b1001110;
            4'hD: hex7 = 7'b0111101;
            4'hE: hex7 = 7'b1001111;
            default: hex7 = 7'b1000111;
        endcase
    endfunction

    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic [1:0]    deb;
    logic [DW-1:0] deb_cnt [2];

    logic [TW-1:0] pre;
    logic [TW-1:0] pre_n;
    logic          tick;
    logic [VW-1:0] value_n;
    logic          wrap_n;

    logic [SW-1:0] scan;
    logic [IW-1:0] idx;
    logic [3:0]    nib;
    logic          blank;
    logic          all_zero;
    logic [6:0]    seg_raw;
    logic [DIGITS-1:0] dig_raw;

    // Button synchroniser and per-button stable-sample debounce
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync_a <= BTN;
            sync_b <= sync_a;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] != deb[i]) begin
                    if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        deb[i]     <= sync_b[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DW'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Count step: clear dominates, otherwise up/down on tick with wrap or clamp
    always_comb begin
        tick    = (pre == TW'(TICK_DIV - 1));
        pre_n   = tick ? '0 : pre + TW'(1);
        value_n = VALUE;
        wrap_n  = 1'b0;
        if (deb == 2'b11) begin
            value_n = '0;
            pre_n   = '0;
        end else if (tick && deb == 2'b01) begin
            if (&VALUE) begin
                if (!SATURATE) begin
                    value_n = '0;
                    wrap_n  = 1'b1;
                end
            end else begin
                value_n = VALUE + VW'(1);
            end
        end else if (tick && deb == 2'b10) begin
            if (VALUE == '0) begin
                if (!SATURATE) begin
                    value_n = '1;
                    wrap_n  = 1'b1;
                end
            end else begin
                value_n = VALUE - VW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre   <= '0;
            VALUE <= '0;
            WRAP  <= 1'b0;
        end else begin
            pre   <= pre_n;
            VALUE <= value_n;
            WRAP  <= wrap_n;
        end
    end

    // Segment pattern and select for the digit currently being scanned
    always_comb begin
        nib      = 4'h0;
        blank    = 1'b0;
        all_zero = 1'b1;
        dig_raw  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_raw[i] = (idx == IW'(i));
            if (idx == IW'(i)) nib = VALUE[4*i +: 4];
        end
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (VALUE[4*i +: 4] == 4'h0);
            if (idx == IW'(i) && all_zero) blank = 1'b1;
        end
        seg_raw = (BLANK_LZ && blank) ? 7'b0000000 : hex7(nib);
    end

    // Scan timing and registered display outputs (SEG/DIG update together)
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            scan <= '0;
            idx  <= '0;
            SEG  <= 7'b1111110 ^ SEG_POL;
            DIG  <= DIGITS'(1) ^ DIG_POL;
        end else begin
            if (scan == SW'(SCAN_DIV - 1)) begin
                scan <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                scan <= scan + SW'(1);
            end
            SEG <= seg_raw ^ SEG_POL;
            DIG <= dig_raw ^ DIG_POL;
        end
    end

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Directed bench: four configurations of seg7_scan_counter share clock, reset and buttons.
module tb_seg7_scan_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn = 2'b00;

    logic [6:0] seg_w, seg_s, seg_b, seg_i;
    logic [1:0] dig_w, dig_s, dig_b, dig_i;
    logic [7:0] value_w, value_s, value_b, value_i;
    logic       wrap_w, wrap_s, wrap_b, wrap_i;

    int k = 0;
    int n_checks = 0;
    int n_err = 0;
    bit sat_wrap_seen = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_counter #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DEB_CYCLES(3))
        u_w (.CLK(clk), .RST_N(rst_n), .BTN(btn), .SEG(seg_w), .DIG(dig_w), .VALUE(value_w), .WRAP(wrap_w));
    seg7_scan_counter #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DEB_CYCLES(3), .SATURATE(1'b1))
        u_s (.CLK(clk), .RST_N(rst_n), .BTN(btn), .SEG(seg_s), .DIG(dig_s), .VALUE(value_s), .WRAP(wrap_s));
    seg7_scan_counter #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DEB_CYCLES(3), .BLANK_LZ(1'b1))
        u_b (.CLK(clk), .RST_N(rst_n), .BTN(btn), .SEG(seg_b), .DIG(dig_b), .VALUE(value_b), .WRAP(wrap_b));
    seg7_scan_counter #(.DIGITS(2), .TICK_DIV(4), .SCAN_DIV(3), .DEB_CYCLES(3),
                        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1))
        u_i (.CLK(clk), .RST_N(rst_n), .BTN(btn), .SEG(seg_i), .DIG(dig_i), .VALUE(value_i), .WRAP(wrap_i));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        k++;
        if (wrap_s) sat_wrap_seen = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = 0;
    endtask

    task automatic check_reset_state();
        check("rst_value_w", 32'(value_w), 32'h00);
        check("rst_wrap_w", 32'(wrap_w), 32'h0);
        check("rst_dig_w", 32'(dig_w), 32'h1);
        check("rst_seg_w", 32'(seg_w), 32'h7E);
        check("rst_seg_i", 32'(seg_i), 32'h01);
        check("rst_dig_i", 32'(dig_i), 32'h2);
        check("rst_value_i", 32'(value_i), 32'h00);
        check("rst_wrap_i", 32'(wrap_i), 32'h0);
        check("rst_value_s", 32'(value_s), 32'h00);
        check("rst_seg_s", 32'(seg_s), 32'h7E);
        check("rst_dig_s", 32'(dig_s), 32'h1);
        check("rst_value_b", 32'(value_b), 32'h00);
        check("rst_wrap_b", 32'(wrap_b), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Idle after reset: zero display, scan alternating every 3 cycles
        do_reset();
        check_reset_state();
        while (k < 40) begin
            cyc();
            check("idle_value", 32'(value_w), 32'h00);
            check("idle_wrap", 32'(wrap_w), 32'h0);
            check("idle_dig", 32'(dig_w), ((((k - 1) / 3) % 2) != 0) ? 32'h2 : 32'h1);
            check("idle_seg", 32'(seg_w), 32'h7E);
            check("idle_seg_blank", 32'(seg_b), (dig_b == 2'b10) ? 32'h00 : 32'h7E);
        end

        // Short glitches on BTN[0] never reach the debounced state
        do_reset();
        repeat (5) begin
            btn = 2'b01;
            cyc();
            cyc();
            btn = 2'b00;
            repeat (5) cyc();
        end
        repeat (8) cyc();
        check("glitch_value", 32'(value_w), 32'h00);
        check("glitch_wrap_seen", 32'(sat_wrap_seen), 32'h0);

        // Up, down through 0, up through FF, then clear and hold
        do_reset();
        sat_wrap_seen = 1'b0;
        while (k < 340) begin
            cyc();
            case (k)
                2:   btn = 2'b01;
                6:   btn = 2'b10;
                22:  btn = 2'b01;
                274: btn = 2'b11;
                300: btn = 2'b00;
                320: btn = 2'b01;
                default: ;
            endcase
            if (k <= 40) check("wrap_pulse", 32'(wrap_w), (k == 16 || k == 36) ? 32'h1 : 32'h0);
            if (k >= 280 && k <= 320) check("clear_hold", 32'(value_w), 32'h00);
            case (k)
                7:   check("deb_before", 32'(value_w), 32'h00);
                8:   check("deb_first_step", 32'(value_w), 32'h01);
                12:  check("down_to_00", 32'(value_w), 32'h00);
                16:  begin
                         check("down_wrap_ff", 32'(value_w), 32'hFF);
                         check("sat_down_hold", 32'(value_s), 32'h00);
                     end
                24:  check("at_fd", 32'(value_w), 32'hFD);
                28:  check("up_fe", 32'(value_w), 32'hFE);
                32:  check("up_ff", 32'(value_w), 32'hFF);
                36:  begin
                         check("up_wrap_00", 32'(value_w), 32'h00);
                         check("sat_value_36", 32'(value_s), 32'h03);
                     end
                279: check("before_clear", 32'(value_w), 32'h3C);
                328: check("prescale_cleared", 32'(value_w), 32'h00);
                329: check("first_after_clear", 32'(value_w), 32'h01);
                default: ;
            endcase
        end
        check("sat_wrap_b", 32'(sat_wrap_seen), 32'h0);

        // Long up run: blanking at 0A, wrap vs saturate at FF
        do_reset();
        sat_wrap_seen = 1'b0;
        while (k < 1040) begin
            cyc();
            if (k == 2) btn = 2'b01;
            case (k)
                44:   begin
                          check("value_0a", 32'(value_w), 32'h0A);
                          check("value_b_0a", 32'(value_b), 32'h0A);
                      end
                45:   begin
                          check("blank_dig0", 32'(dig_b), 32'h1);
                          check("blank_seg0", 32'(seg_b), 32'h77);
                      end
                46:   begin
                          check("blank_dig1", 32'(dig_b), 32'h2);
                          check("blank_seg1", 32'(seg_b), 32'h00);
                          check("noblank_seg1", 32'(seg_w), 32'h7E);
                      end
                1024: begin
                          check("sat_reach_ff", 32'(value_s), 32'hFF);
                          check("wrap_at_ff", 32'(value_w), 32'hFF);
                      end
                1028: begin
                          check("wrap_ff_00", 32'(value_w), 32'h00);
                          check("wrap_ff_pulse", 32'(wrap_w), 32'h1);
                          check("sat_hold_ff", 32'(value_s), 32'hFF);
                      end
                1029: check("wrap_ff_end", 32'(wrap_w), 32'h0);
                default: ;
            endcase
        end
        check("sat_end_ff", 32'(value_s), 32'hFF);
        check("sat_wrap_d", 32'(sat_wrap_seen), 32'h0);

        // Reset mid-count at 7E while digit 1 is displayed
        do_reset();
        while (k < 508) begin
            cyc();
            if (k == 2) btn = 2'b01;
        end
        check("pre_rst_value", 32'(value_w), 32'h7E);
        check("pre_rst_dig", 32'(dig_w), 32'h2);
        check("pre_rst_dig_i", 32'(dig_i), 32'h1);
        do_reset();
        check_reset_state();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
